// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control FSM: opcodes, functs,
// state numbering and the datapath select codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR, S_MEM_RD,
    S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ILLEGAL
  } state_t;

  localparam logic [1:0] PC_SRC_ALU = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_JMP = 2'b10;
  localparam logic [1:0] PC_SRC_RS  = 2'b11;

  localparam logic [1:0] ALU_PC4    = 2'b00;
  localparam logic [1:0] ALU_BRTGT  = 2'b01;
  localparam logic [1:0] ALU_INSTR  = 2'b10;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_RA  = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MDR  = 2'b01;
  localparam logic [1:0] WB_PC   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_phase;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
  } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Opcode/funct classifier: picks the state that follows DECODE.
module mc_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_t     next_state
);

  always_comb begin
    next_state = S_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU: next_state = S_EXEC_R;
          FN_JR:           next_state = S_JR;
          default:         next_state = S_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
      OP_ORI, OP_XORI, OP_LUI: next_state = S_EXEC_I;
      OP_LW, OP_SW:            next_state = S_MEM_ADDR;
      OP_BEQ, OP_BNE:          next_state = S_BRANCH;
      OP_J:                    next_state = S_JUMP;
      OP_JAL:                  next_state = S_JAL;
      default:                 next_state = S_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS-subset core: fetch/decode/execute/
// memory/writeback sequencing over a req/ready memory with an access timeout.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_phase,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_src,
  output logic       illegal,
  output logic [3:0] state_o
);

  // Timeout fires when the wait that would bring the count to MEM_TIMEOUT also misses.
  localparam logic [7:0] WAIT_LAST = 8'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t     state_q, state_d, dec_state;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       in_mem, timeout;
  ctrl_t      ctrl, ctrl_o;

  mc_decode u_decode (
    .opcode     (opcode),
    .funct      (funct),
    .next_state (dec_state)
  );

  always_comb begin
    in_mem  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    timeout = in_mem && !mem_ready && (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);

    wait_d = '0;
    if (in_mem && !mem_ready)
      wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;

    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE:   state_d = dec_state;
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_WB_R, S_WB_I, S_WB_MEM,
      S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_ILLEGAL;
    endcase
    if (timeout) state_d = S_ILLEGAL;

    illegal_d = illegal_q || (state_d == S_ILLEGAL);
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req  = 1'b1;
        ctrl.ir_write = mem_ready;
        ctrl.pc_write = mem_ready;
        ctrl.pc_src   = PC_SRC_ALU;
        ctrl.alu_phase = ALU_PC4;
      end
      S_DECODE:   ctrl.alu_phase = ALU_BRTGT;
      S_EXEC_R, S_EXEC_I, S_MEM_ADDR: ctrl.alu_phase = ALU_INSTR;
      S_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = DST_RD;
        ctrl.wb_src    = WB_ALU;
      end
      S_WB_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = DST_RT;
        ctrl.wb_src    = WB_ALU;
      end
      S_MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = DST_RT;
        ctrl.wb_src    = WB_MDR;
      end
      S_MEM_WR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_phase = ALU_INSTR;
        ctrl.pc_src    = PC_SRC_BR;
        ctrl.pc_write  = (opcode == OP_BNE) ? !zero : zero;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_SRC_JMP;
      end
      // PC already holds PC+4, which is the link value written to $31.
      S_JAL: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_src    = PC_SRC_JMP;
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = DST_RA;
        ctrl.wb_src    = WB_PC;
      end
      S_JR: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_SRC_RS;
      end
      default: ctrl = '0;
    endcase
    ctrl_o = rst_n ? ctrl : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
    end
  end

  assign mem_req   = ctrl_o.mem_req;
  assign mem_we    = ctrl_o.mem_we;
  assign iord      = ctrl_o.iord;
  assign ir_write  = ctrl_o.ir_write;
  assign pc_write  = ctrl_o.pc_write;
  assign pc_src    = ctrl_o.pc_src;
  assign alu_phase = ctrl_o.alu_phase;
  assign reg_write = ctrl_o.reg_write;
  assign reg_dst   = ctrl_o.reg_dst;
  assign wb_src    = ctrl_o.wb_src;
  assign illegal   = rst_n & illegal_q;
  assign state_o   = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed cases then random instruction streams,
// each cycle compared against a per-instruction phase model.
module tb_multicycle_control;

  localparam int TO = 4;
  localparam int FETCH = 0, DECODE = 1, EXEC_R = 2, WB_R = 3, EXEC_I = 4, WB_I = 5,
                 MEM_ADDR = 6, MEM_RD = 7, WB_MEM = 8, MEM_WR = 9, BRANCH = 10,
                 JUMP = 11, JAL = 12, JR = 13, ILL = 14;
  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_BNE = 5,
                 C_J = 6, C_JAL = 7, C_JR = 8, C_ILL = 9;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_phase;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic       illegal;
  } exp_t;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write, illegal;
  logic [1:0] pc_src, alu_phase, reg_dst, wb_src;
  logic [3:0] state_o;
  int total = 0, bad = 0;

  logic [5:0] r_fn [14] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110,
                            6'b000111, 6'b100000, 6'b100010, 6'b100100, 6'b100101,
                            6'b100110, 6'b100111, 6'b101010, 6'b101011};
  logic [5:0] i_op [7] = '{6'b001000, 6'b001010, 6'b001011, 6'b001100, 6'b001101,
                           6'b001110, 6'b001111};
  logic [5:0] legal_op [9] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
                               6'b001000, 6'b100011, 6'b101011, 6'b001111};

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_phase(alu_phase),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_src(wb_src), .illegal(illegal),
    .state_o(state_o)
  );

  function automatic exp_t blank(input int st);
    exp_t e;
    e = '0;
    e.st = 4'(st);
    return e;
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) begin
      if (fn == 6'b001000) return C_JR;
      foreach (r_fn[i]) if (r_fn[i] == fn) return C_R;
      return C_ILL;
    end
    foreach (i_op[i]) if (i_op[i] == op) return C_I;
    case (op)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000101: return C_BNE;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      default:   return C_ILL;
    endcase
  endfunction

  task automatic cyc(input logic mr, input exp_t e, input string tag);
    exp_t o;
    mem_ready = mr;
    @(negedge clk);
    o = {state_o, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_phase,
         reg_write, reg_dst, wb_src, illegal};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) cyc(1'b1, blank(FETCH), "reset");
    rst_n = 1'b1;
  endtask

  // One memory access: `waits` not-ready cycles, then the completing cycle.
  task automatic mem_access(input int st, input int waits, input logic we, input string tag);
    exp_t e;
    e = blank(st);
    e.mem_req = 1'b1;
    e.mem_we  = we;
    e.iord    = (st != FETCH);
    for (int i = 0; i < waits; i++) cyc(1'b0, e, tag);
    if (st == FETCH) begin
      e.ir_write = 1'b1;
      e.pc_write = 1'b1;
    end
    cyc(1'b1, e, tag);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int wf, input int wm, input string tag);
    int c;
    exp_t e;
    c = classify(op, fn);
    opcode = 6'($urandom);
    funct  = 6'($urandom);
    zero   = z;
    mem_access(FETCH, wf, 1'b0, {tag, "/fetch"});
    opcode = op;
    funct  = fn;
    e = blank(DECODE); e.alu_phase = 2'b01;
    cyc(1'($urandom), e, {tag, "/decode"});
    case (c)
      C_R, C_I: begin
        e = blank(c == C_R ? EXEC_R : EXEC_I); e.alu_phase = 2'b10;
        cyc(1'($urandom), e, {tag, "/exec"});
        e = blank(c == C_R ? WB_R : WB_I); e.reg_write = 1'b1;
        e.reg_dst = (c == C_R) ? 2'b01 : 2'b00;
        cyc(1'($urandom), e, {tag, "/wb"});
      end
      C_LW, C_SW: begin
        e = blank(MEM_ADDR); e.alu_phase = 2'b10;
        cyc(1'($urandom), e, {tag, "/addr"});
        if (c == C_LW) begin
          mem_access(MEM_RD, wm, 1'b0, {tag, "/memrd"});
          e = blank(WB_MEM); e.reg_write = 1'b1; e.wb_src = 2'b01;
          cyc(1'($urandom), e, {tag, "/wbmem"});
        end else begin
          mem_access(MEM_WR, wm, 1'b1, {tag, "/memwr"});
        end
      end
      C_BEQ, C_BNE: begin
        e = blank(BRANCH); e.alu_phase = 2'b10; e.pc_src = 2'b01;
        e.pc_write = (c == C_BEQ) ? z : !z;
        cyc(1'($urandom), e, {tag, "/branch"});
      end
      C_J: begin
        e = blank(JUMP); e.pc_write = 1'b1; e.pc_src = 2'b10;
        cyc(1'($urandom), e, {tag, "/jump"});
      end
      C_JAL: begin
        e = blank(JAL); e.pc_write = 1'b1; e.pc_src = 2'b10; e.reg_write = 1'b1;
        e.reg_dst = 2'b10; e.wb_src = 2'b10;
        cyc(1'($urandom), e, {tag, "/jal"});
      end
      C_JR: begin
        e = blank(JR); e.pc_write = 1'b1; e.pc_src = 2'b11;
        cyc(1'($urandom), e, {tag, "/jr"});
      end
      default: begin
        e = blank(ILL); e.illegal = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'($urandom), e, {tag, "/illegal"});
        do_reset(2);
      end
    endcase
  endtask

  initial begin
    exp_t e;
    logic [5:0] op, fn;

    do_reset(3);
    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, "add");
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 3, "lw_wait3");
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, "beq_z1");
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, "beq_z0");
    run_instr(6'b000101, 6'b000000, 1'b1, 0, 0, "bne_z1");
    run_instr(6'b000101, 6'b000000, 1'b0, 0, 0, "bne_z0");
    run_instr(6'b000011, 6'b000000, 1'b0, 0, 0, "jal");
    run_instr(6'b000000, 6'b001000, 1'b0, 0, 0, "jr");
    run_instr(6'b101011, 6'b000000, 1'b0, 2, 3, "sw_wait");
    run_instr(6'b001101, 6'b000000, 1'b0, 3, 0, "ori_fwait");
    run_instr(6'b000010, 6'b000000, 1'b0, 1, 0, "j");
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, "bad_op");
    run_instr(6'b000000, 6'b000001, 1'b0, 0, 0, "bad_funct");

    // Fetch never answered: four wait cycles, then ILLEGAL until reset.
    e = blank(FETCH); e.mem_req = 1'b1;
    for (int i = 0; i < TO; i++) cyc(1'b0, e, "timeout/wait");
    e = blank(ILL); e.illegal = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1, e, "timeout/sticky");
    do_reset(2);

    // Reset in the middle of a load abandons the access.
    opcode = 6'b100011;
    mem_access(FETCH, 0, 1'b0, "abort/fetch");
    e = blank(DECODE); e.alu_phase = 2'b01; cyc(1'b0, e, "abort/decode");
    e = blank(MEM_ADDR); e.alu_phase = 2'b10; cyc(1'b0, e, "abort/addr");
    e = blank(MEM_RD); e.mem_req = 1'b1; e.iord = 1'b1;
    cyc(1'b0, e, "abort/memrd");
    cyc(1'b0, e, "abort/memrd");
    do_reset(1);
    run_instr(6'b000000, 6'b101010, 1'b0, 0, 0, "slt_after_abort");

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        op = legal_op[$urandom_range(0, 8)];
        fn = (op == 6'b000000 && $urandom_range(0, 4) != 0)
             ? r_fn[$urandom_range(0, 13)] : 6'($urandom);
        if (op == 6'b000000 && $urandom_range(0, 7) == 0) fn = 6'b001000;
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      run_instr(op, fn, 1'($urandom), $urandom_range(0, TO - 1),
                $urandom_range(0, TO - 1), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS-subset core.
- Sequences instruction fetch, decode, execute, memory and writeback over a shared single-port memory, using a req/ready handshake.
- Drives the datapath muxes, PC/IR/register-file write enables, and an `alu_phase` select.
- In phase "instruction op", the existing combinational ALU controller decodes opcode/funct into `aluOp`, `in1Mux` and `in2Mux`.

Parameters:
- MEM_TIMEOUT, 255, maximum cycles to wait for `mem_ready` per access; 0 disables the timeout.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete; sampled only while `mem_req`=1
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR (and MDR)
- pc_write  out  1  PC load enable
- pc_src  out  2  00 = ALU result (PC+4), 01 = ALUOut (branch target), 10 = {PC[31:28], IR[25:0], 00}, 11 = $rs
- alu_phase  out  2  00 = PC+4, 01 = PC+(SignExt(imm)<<2), 10 = instruction op via ALU controller
- reg_write  out  1  register-file write enable
- reg_dst  out  2  00 = rt, 01 = rd, 10 = $31
- wb_src  out  2  00 = ALUOut, 01 = MDR, 10 = PC
- illegal  out  1  sticky: unsupported instruction or memory timeout
- state_o  out  4  current state, debug

Behaviour:
- Reset: `rst_n`=0 at a clock edge sets state to FETCH and clears the wait counter and `illegal`. While `rst_n`=0, all outputs are forced to 0. A reset mid-access abandons the access.
- Outputs are Moore, decoded from state. There are three exceptions:
  - FETCH: `ir_write` and `pc_write` = `mem_ready`.
  - BRANCH: `pc_write` = `zero` (beq) or ~`zero` (bne).
  - Memory states: state advances only on `mem_ready`.
- State encodings 0–14, in this order:
  - FETCH: `mem_req`=1, `iord`=0, `alu_phase`=00, `pc_src`=00. On `mem_ready` → DECODE; otherwise hold.
  - DECODE: `alu_phase`=01 (branch target into ALUOut). Next state:
    - opcode 000000 with funct in {000000, 000010, 000011, 000100, 000110, 000111, 100000, 100010, 100100, 100101, 100110, 100111, 101010, 101011} → EXEC_R
    - opcode 000000 with funct 001000 → JR
    - opcodes 001000, 001010, 001011, 001100, 001101, 001110, 001111 → EXEC_I
    - opcodes 100011, 101011 → MEM_ADDR
    - opcodes 000100, 000101 → BRANCH
    - opcode 000010 → JUMP
    - opcode 000011 → JAL
    - anything else → ILLEGAL
  - EXEC_R: `alu_phase`=10 → WB_R.
  - WB_R: `reg_write`=1, `reg_dst`=01, `wb_src`=00 → FETCH.
  - EXEC_I: `alu_phase`=10 → WB_I.
  - WB_I: `reg_write`=1, `reg_dst`=00, `wb_src`=00 → FETCH.
  - MEM_ADDR: `alu_phase`=10 → MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: `mem_req`=1, `iord`=1, `ir_write`=0. MDR captures data on `mem_ready`; then → WB_MEM.
  - WB_MEM: `reg_write`=1, `reg_dst`=00, `wb_src`=01 → FETCH.
  - MEM_WR: `mem_req`=1, `mem_we`=1, `iord`=1. On `mem_ready` → FETCH.
  - BRANCH: `alu_phase`=10, `pc_src`=01 → FETCH.
  - JUMP: `pc_write`=1, `pc_src`=10 → FETCH.
  - JAL: `pc_write`=1, `pc_src`=10, `reg_write`=1, `reg_dst`=10, `wb_src`=10 → FETCH. PC already holds PC+4.
  - JR: `pc_write`=1, `pc_src`=11 → FETCH.
  - ILLEGAL: all enables 0, `illegal`=1. Stays until reset.
- Latency with zero-wait memory (`mem_ready` in the first cycle of the request):
  - R-type, I-type ALU, sw: 4 cycles
  - lw: 5 cycles
  - beq, bne, j, jal, jr: 3 cycles
- Handshake:
  - `mem_req`, `mem_we` and `iord` are held stable from assertion until the cycle `mem_ready` is seen.
  - `mem_req` drops in the cycle after completion, because the state has changed.
  - `mem_ready` outside FETCH/MEM_RD/MEM_WR is ignored.
- Timeout:
  - An 8-bit wait counter clears on entering any memory state and increments each cycle `mem_ready`=0.
  - If the counter reaches MEM_TIMEOUT (nonzero) with `mem_ready` still 0 → ILLEGAL.
  - `mem_ready` arriving in the same cycle as the counter hitting the limit counts as completion; the timeout does not fire.

Decomposition:
- Package `mips_ctrl_pkg` holds:
  - opcode and funct localparams
  - state encodings
  - `pc_src`, `reg_dst`, `wb_src` and `alu_phase` encodings
- One sub-module, `mc_decode`: combinational opcode/funct classifier that produces DECODE's next state.

Test Plan:
- Reset held 3 cycles, then released with `mem_ready`=1: all outputs 0 during reset; first cycle after release `mem_req`=1, `iord`=0, `ir_write`=1, `pc_write`=1.
- add (opcode 000000, funct 100000), zero-wait: states FETCH → DECODE → EXEC_R → WB_R → FETCH; `reg_write`=1 with `reg_dst`=01 in cycle 4 only.
- lw (100011) with `mem_ready` delayed 3 cycles in MEM_RD: `mem_req`/`iord` stable for 4 cycles; then WB_MEM with `wb_src`=01, `reg_dst`=00.
- beq (000100): `zero`=1 → `pc_write`=1, `pc_src`=01 in BRANCH. Repeat with `zero`=0 → `pc_write`=0. bne gives the inverse results.
- jal (000011): JAL state has `pc_write`=1, `pc_src`=10, `reg_write`=1, `reg_dst`=10, `wb_src`=10; jr (funct 001000) has `pc_src`=11.
- opcode 111111, or R-type funct 000001 → ILLEGAL with sticky `illegal`=1. Separately, MEM_TIMEOUT=4 with `mem_ready` never asserted in FETCH → ILLEGAL after 4 wait cycles; `rst_n`=0 clears both cases.
